instruction_c_packer: RTL and testbench
=======================================

// Module: instruction_c_packer
// PURPOSE
//  Encoder side of the RV32C path: accepts a stream of 32-bit RV32I instructions, rewrites
//  compressible ones into 16-bit RVC form and packs the resulting halfwords little-endian
//  into 32-bit memory words. Sits between the program/code generator and instruction memory.
// PARAMETERS
//  CNT_W  16  width of saturating compressed-instruction counter
// PORTS
//  iCLK         in   1      clock, rising edge
//  iRST         in   1      reset, asynchronous, active-high
//  iVALID       in   1      iINSTR valid
//  iINSTR       in   32     RV32I instruction
//  oREADY       out  1      input accepted when iVALID && oREADY
//  iFLUSH       in   1      level request: emit pending halfword padded with c.nop
//  oVALID       out  1      oWORD valid
//  oWORD        out  32     packed word, bits[15:0] = earlier halfword
//  iREADY       in   1      downstream accepts oWORD when oVALID && iREADY
//  oHALF        out  1      1 = a halfword is pending (state HALF)
//  oCCOUNT      out  CNT_W  number of instructions emitted compressed, saturating
// BEHAVIOUR
//  Reset: state EMPTY, pending half 0, oVALID 0, oWORD 0, oCCOUNT 0; oREADY 1 once reset released.
//  Output register single entry: slot_free = !oVALID || iREADY; oREADY = slot_free && !iFLUSH.
//  Latency: accept at edge N -> oVALID from edge N (visible cycle N+1) when a word completes.
//  Encoding rules (first match wins), else not compressible:
//   addi rd,x0,imm, rd!=0, imm in [-32,31]             -> c.li
//   addi rd,rd,imm, rd!=0, imm!=0, imm in [-32,31]     -> c.addi
//   addi rd',x2,imm, rd' in x8..x15, imm%4==0, 4..1020 -> c.addi4spn
//   add rd,x0,rs2, rd!=0, rs2!=0                       -> c.mv
//   add rd,rd,rs2, rd!=0, rs2!=0                       -> c.add
//  State machine (on accepted instruction, C = 16-bit code, I = 32-bit instr):
//   EMPTY + C: pend<=C, ->HALF, no output.   EMPTY + I: oWORD<=I, ->EMPTY.
//   HALF + C: oWORD<={C,pend}, ->EMPTY.      HALF + I: oWORD<={I[15:0],pend}, pend<=I[31:16], stay HALF.
//  Flush: when iFLUSH && slot_free: HALF -> oWORD<={16'h0001,pend}, ->EMPTY; EMPTY -> no-op.
//   No input accepted while iFLUSH high; iFLUSH may stay high, repeated flush in EMPTY is no-op.
//  oVALID held with stable oWORD until iREADY; cleared on handshake unless a new word loads same edge.
//  oCCOUNT += 1 per accepted compressed instruction; holds at all-ones.
//  Reset asserted mid-stream: pending halfword and unsent oWORD discarded, state EMPTY.
// CONFIGURATION
//  RVC_LOADSTORE_EN defined: additionally
//   lw rd',off(rs1'), both in x8..x15, off%4==0, 0..124 -> c.lw
//   sw rs2',off(rs1'), same constraints              -> c.sw
//  Not defined: all loads/stores pass uncompressed.
// STRUCTURE
//  Shared package/include: RV32I opcodes (OP_IMM, OP, LOAD, STORE), funct3 values,
//   RVC quadrant/funct3 codes, C_NOP = 16'h0001.
//  Sub-module instruction_c_encoder: combinational, iINSTR -> {oCOMP, oCODE[15:0]};
//   packer holds FSM, pending register, output register, counter.
// TESTING
//  li a0,5 0x00500513 then add a0,a0,a1 0x00B50533 -> one word 0x952E4515, oCCOUNT=2.
//  lui x5 0x123452B7 in EMPTY -> 0x123452B7; li a0,5 then lui -> 0x52B74515, oHALF=1;
//   iFLUSH -> 0x00011234, oHALF=0.
//  addi x8,x2,16 0x01010413 + addi a0,a0,-1 0xFFF50513 -> 0x157D0800;
//   addi x8,x2,0 0x00010413 -> uncompressed 0x00010413; add a0,x0,a1 -> 0x852E.
//  iREADY=0 for 5 cycles with word pending -> oWORD stable, oREADY=0, no input lost.
//  iRST pulse in HALF with oVALID=1 -> oVALID=0, oHALF=0 immediately; next li+add packs cleanly.
//  RVC_LOADSTORE_EN: lw x8,4(x9) 0x0044A403 -> 0x40C0; undefined -> passes 0x0044A403.

Source files
------------

// File: rtl/instruction_c_packer_pkg.sv
// Shared RV32I / RVC encoding constants for the compressed-instruction packer.
// The optional load/store compression is enabled by defining RVC_LOADSTORE_EN.
package instruction_c_packer_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] CF3_ADDI4SPN = 3'b000;
  localparam logic [2:0] CF3_ADDI     = 3'b000;
  localparam logic [2:0] CF3_LI       = 3'b010;
  localparam logic [2:0] CF3_LW       = 3'b010;
  localparam logic [2:0] CF3_SW       = 3'b110;
  localparam logic [3:0] CF4_MV       = 4'b1000;
  localparam logic [3:0] CF4_ADD      = 4'b1001;

  localparam logic [15:0] C_NOP = 16'h0001;

  // Packer states; r_state is also exported as oHALF.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  // Registers reachable by the 3-bit RVC register fields (x8..x15).
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/instruction_c_encoder.sv
// Combinational RV32I -> RVC rewriter; oCOMP=1 when oCODE holds a valid 16-bit form.
// Loads/stores are only considered when RVC_LOADSTORE_EN is defined.
module instruction_c_encoder
  import instruction_c_packer_pkg::*;
(
  input  logic [31:0] iINSTR,
  output logic        oCOMP,
  output logic [15:0] oCODE
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_f7;
  logic [11:0] w_imm_i;
  logic        w_is_addi;
  logic        w_is_add;
  logic        w_imm6_ok;
  logic        w_spn_ok;

  assign w_opcode = iINSTR[6:0];
  assign w_rd     = iINSTR[11:7];
  assign w_f3     = iINSTR[14:12];
  assign w_rs1    = iINSTR[19:15];
  assign w_rs2    = iINSTR[24:20];
  assign w_f7     = iINSTR[31:25];
  assign w_imm_i  = iINSTR[31:20];

  assign w_is_addi = (w_opcode == OP_IMM) && (w_f3 == F3_ADDI);
  assign w_is_add  = (w_opcode == OP) && (w_f3 == F3_ADD) && (w_f7 == 7'b0);
  // imm fits a signed 6-bit field when bits [11:5] are a pure sign extension
  assign w_imm6_ok = (w_imm_i[11:5] == 7'h00) || (w_imm_i[11:5] == 7'h7F);
  assign w_spn_ok  = (w_imm_i[11:10] == 2'b00) && (w_imm_i[1:0] == 2'b00) && (w_imm_i != 12'h0);

`ifdef RVC_LOADSTORE_EN
  logic [11:0] w_imm_s;
  logic        w_lw_ok;
  logic        w_sw_ok;

  assign w_imm_s = {iINSTR[31:25], iINSTR[11:7]};
  assign w_lw_ok = (w_opcode == LOAD) && (w_f3 == F3_LW) && is_creg(w_rd) && is_creg(w_rs1)
                   && (w_imm_i[11:7] == 5'b0) && (w_imm_i[1:0] == 2'b00);
  assign w_sw_ok = (w_opcode == STORE) && (w_f3 == F3_SW) && is_creg(w_rs2) && is_creg(w_rs1)
                   && (w_imm_s[11:7] == 5'b0) && (w_imm_s[1:0] == 2'b00);
`endif

  always_comb begin
    oCOMP = 1'b0;
    oCODE = 16'h0000;
    if (w_is_addi && (w_rs1 == 5'd0) && (w_rd != 5'd0) && w_imm6_ok) begin
      oCOMP = 1'b1;
      oCODE = {CF3_LI, w_imm_i[5], w_rd, w_imm_i[4:0], RVC_Q1};
    end else if (w_is_addi && (w_rs1 == w_rd) && (w_rd != 5'd0) && (w_imm_i != 12'h0) && w_imm6_ok) begin
      oCOMP = 1'b1;
      oCODE = {CF3_ADDI, w_imm_i[5], w_rd, w_imm_i[4:0], RVC_Q1};
    end else if (w_is_addi && (w_rs1 == 5'd2) && is_creg(w_rd) && w_spn_ok) begin
      oCOMP = 1'b1;
      oCODE = {CF3_ADDI4SPN, w_imm_i[5:4], w_imm_i[9:6], w_imm_i[2], w_imm_i[3], w_rd[2:0], RVC_Q0};
    end else if (w_is_add && (w_rs1 == 5'd0) && (w_rd != 5'd0) && (w_rs2 != 5'd0)) begin
      oCOMP = 1'b1;
      oCODE = {CF4_MV, w_rd, w_rs2, RVC_Q2};
    end else if (w_is_add && (w_rs1 == w_rd) && (w_rd != 5'd0) && (w_rs2 != 5'd0)) begin
      oCOMP = 1'b1;
      oCODE = {CF4_ADD, w_rd, w_rs2, RVC_Q2};
    end
`ifdef RVC_LOADSTORE_EN
    else if (w_lw_ok) begin
      oCOMP = 1'b1;
      oCODE = {CF3_LW, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6], w_rd[2:0], RVC_Q0};
    end else if (w_sw_ok) begin
      oCOMP = 1'b1;
      oCODE = {CF3_SW, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6], w_rs2[2:0], RVC_Q0};
    end
`endif
  end

endmodule

// File: rtl/instruction_c_packer.sv
// Packs a stream of RV32I instructions, compressed where possible, into little-endian 32-bit words.
// Build option RVC_LOADSTORE_EN also compresses lw/sw (handled inside instruction_c_encoder).
//
// Handshakes: input beat transfers on a rising edge where iVALID && oREADY; output word
// transfers where oVALID && iREADY. oVALID/oWORD hold stable until that transfer.
module instruction_c_packer
  import instruction_c_packer_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  input  logic [31:0]      iINSTR,
  output logic             oREADY,
  input  logic             iFLUSH,
  output logic             oVALID,
  output logic [31:0]      oWORD,
  input  logic             iREADY,
  output logic             oHALF,
  output logic [CNT_W-1:0] oCCOUNT
);

  logic [0:0]       r_state;
  logic [15:0]      r_pend;
  logic             r_valid;
  logic [31:0]      r_word;
  logic [CNT_W-1:0] r_ccount;

  logic        w_comp;
  logic [15:0] w_code;
  logic        w_slot_free;
  logic        w_accept;
  logic        w_flush_fire;
  logic        w_load;

  instruction_c_encoder u_enc (
    .iINSTR (iINSTR),
    .oCOMP  (w_comp),
    .oCODE  (w_code)
  );

  assign w_slot_free  = !r_valid || iREADY;
  assign w_accept     = iVALID && w_slot_free && !iFLUSH;
  assign w_flush_fire = iFLUSH && w_slot_free && (r_state == ST_HALF);
  // Every accept produces a word except a compressed one arriving with nothing pending.
  assign w_load       = (w_accept && !((r_state == ST_EMPTY) && w_comp)) || w_flush_fire;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_EMPTY;
      r_pend  <= 16'h0000;
      r_word  <= 32'h0000_0000;
    end else if (w_accept) begin
      if (r_state == ST_EMPTY) begin
        if (w_comp) begin
          r_pend  <= w_code;
          r_state <= ST_HALF;
        end else begin
          r_word <= iINSTR;
        end
      end else begin
        if (w_comp) begin
          r_word  <= {w_code, r_pend};
          r_state <= ST_EMPTY;
        end else begin
          r_word <= {iINSTR[15:0], r_pend};
          r_pend <= iINSTR[31:16];
        end
      end
    end else if (w_flush_fire) begin
      r_word  <= {C_NOP, r_pend};
      r_state <= ST_EMPTY;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (iREADY) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_ccount <= '0;
    end else if (w_accept && w_comp && (r_ccount != {CNT_W{1'b1}})) begin
      r_ccount <= r_ccount + 1'b1;
    end
  end

  assign oREADY  = w_slot_free && !iFLUSH;
  assign oVALID  = r_valid;
  assign oWORD   = r_word;
  assign oHALF   = (r_state == ST_HALF);
  assign oCCOUNT = r_ccount;

endmodule

// File: tb/tb_instruction_c_packer.sv
// Directed bench for instruction_c_packer; counter narrowed to 4 bits so saturation is reachable.
// Expectations follow the RVC encodings worked out by hand for each vector.
module tb_instruction_c_packer;

  localparam int TB_CNT_W = 4;

  logic                iCLK;
  logic                iRST;
  logic                iVALID;
  logic [31:0]         iINSTR;
  logic                oREADY;
  logic                iFLUSH;
  logic                oVALID;
  logic [31:0]         oWORD;
  logic                iREADY;
  logic                oHALF;
  logic [TB_CNT_W-1:0] oCCOUNT;

  int vectors;
  int miscompares;
  int exp_cnt;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  instruction_c_packer #(.CNT_W(TB_CNT_W)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iVALID  (iVALID),
    .iINSTR  (iINSTR),
    .oREADY  (oREADY),
    .iFLUSH  (iFLUSH),
    .oVALID  (oVALID),
    .oWORD   (oWORD),
    .iREADY  (iREADY),
    .oHALF   (oHALF),
    .oCCOUNT (oCCOUNT)
  );

  // clock / reset
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs only change at posedge+1, so a transfer seen at negedge completes on the next edge.
  always @(negedge iCLK) begin
    if (!iRST && oVALID && iREADY) obs_q.push_back(oWORD);
  end

  function automatic logic [TB_CNT_W-1:0] cnt_model();
    return (exp_cnt > 15) ? 4'd15 : exp_cnt[TB_CNT_W-1:0];
  endfunction

  // driver tasks
  task automatic send(input logic [31:0] instr);
    int n;
    n = 0;
    iVALID = 1'b1;
    iINSTR = instr;
    @(negedge iCLK);
    while (!oREADY && n < 50) begin
      @(negedge iCLK);
      n++;
    end
    vectors++;
    if (!oREADY) begin
      miscompares++;
      $display("FAIL send_accept: oREADY got %0b want 1 for instr %h", oREADY, instr);
    end
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
  endtask

  task automatic get_word(output logic [31:0] w, output bit ok);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 40) begin
      @(negedge iCLK);
      n++;
    end
    ok = (obs_q.size() != 0);
    w = ok ? obs_q.pop_front() : 32'hxxxx_xxxx;
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    iVALID = 1'b0;
    iINSTR = 32'h0;
    iFLUSH = 1'b0;
    iREADY = 1'b1;
    exp_cnt = 0;
    repeat (3) @(negedge iCLK);
    vectors++;
    if (oVALID !== 1'b0) begin miscompares++; $display("FAIL reset_ovalid: got %0b want 0", oVALID); end
    vectors++;
    if (oWORD !== 32'h0) begin miscompares++; $display("FAIL reset_oword: got %h want 00000000", oWORD); end
    vectors++;
    if (oHALF !== 1'b0) begin miscompares++; $display("FAIL reset_ohalf: got %0b want 0", oHALF); end
    vectors++;
    if (oCCOUNT !== 4'd0) begin miscompares++; $display("FAIL reset_ccount: got %0d want 0", oCCOUNT); end
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(negedge iCLK);
    vectors++;
    if (oREADY !== 1'b1) begin miscompares++; $display("FAIL reset_oready: got %0b want 1", oREADY); end
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_pack_pair();
    logic [31:0] w;
    bit ok;
    send(32'h00500513);
    send(32'h00B50533);
    exp_cnt += 2;
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h952E4515) begin miscompares++; $display("FAIL pair_word: got %h want 952e4515 (seen=%0b)", w, ok); end
    vectors++;
    if (oCCOUNT !== cnt_model()) begin miscompares++; $display("FAIL pair_ccount: got %0d want %0d", oCCOUNT, cnt_model()); end
    vectors++;
    if (oHALF !== 1'b0) begin miscompares++; $display("FAIL pair_ohalf: got %0b want 0", oHALF); end
  endtask

  task automatic test_uncompressed();
    logic [31:0] w;
    bit ok;
    send(32'h123452B7);
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h123452B7) begin miscompares++; $display("FAIL lui_word: got %h want 123452b7 (seen=%0b)", w, ok); end
    vectors++;
    if (oCCOUNT !== cnt_model()) begin miscompares++; $display("FAIL lui_ccount: got %0d want %0d", oCCOUNT, cnt_model()); end
  endtask

  task automatic test_half_flush();
    logic [31:0] w;
    bit ok;
    send(32'h00500513);
    exp_cnt += 1;
    vectors++;
    if (oHALF !== 1'b1) begin miscompares++; $display("FAIL half_after_li: got %0b want 1", oHALF); end
    send(32'h123452B7);
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h52B74515) begin miscompares++; $display("FAIL half_split_word: got %h want 52b74515 (seen=%0b)", w, ok); end
    vectors++;
    if (oHALF !== 1'b1) begin miscompares++; $display("FAIL half_after_split: got %0b want 1", oHALF); end
    // hold flush several cycles: the extra cycles land in EMPTY and must do nothing
    iFLUSH = 1'b1;
    @(negedge iCLK);
    vectors++;
    if (oREADY !== 1'b0) begin miscompares++; $display("FAIL flush_oready: got %0b want 0", oREADY); end
    repeat (3) @(posedge iCLK);
    #1;
    iFLUSH = 1'b0;
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h00011234) begin miscompares++; $display("FAIL flush_word: got %h want 00011234 (seen=%0b)", w, ok); end
    vectors++;
    if (oHALF !== 1'b0) begin miscompares++; $display("FAIL flush_ohalf: got %0b want 0", oHALF); end
    repeat (2) @(posedge iCLK);
    #1;
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL flush_extra: got %0d extra words want 0", obs_q.size()); end
    vectors++;
    if (oCCOUNT !== cnt_model()) begin miscompares++; $display("FAIL flush_ccount: got %0d want %0d", oCCOUNT, cnt_model()); end
  endtask

  task automatic test_addi_forms();
    logic [31:0] w;
    bit ok;
    send(32'h01010413);
    send(32'hFFF50513);
    exp_cnt += 2;
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h157D0800) begin miscompares++; $display("FAIL spn_addi_word: got %h want 157d0800 (seen=%0b)", w, ok); end
    send(32'h00010413);
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h00010413) begin miscompares++; $display("FAIL spn_zero_word: got %h want 00010413 (seen=%0b)", w, ok); end
    send(32'h00B00533);
    exp_cnt += 1;
    iFLUSH = 1'b1;
    @(posedge iCLK);
    #1;
    iFLUSH = 1'b0;
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h0001852E) begin miscompares++; $display("FAIL mv_word: got %h want 0001852e (seen=%0b)", w, ok); end
    vectors++;
    if (oCCOUNT !== cnt_model()) begin miscompares++; $display("FAIL addi_ccount: got %0d want %0d", oCCOUNT, cnt_model()); end
  endtask

  task automatic test_loadstore();
    logic [31:0] w;
    bit ok;
    send(32'h0044A403);
    send(32'h0084A223);
`ifdef RVC_LOADSTORE_EN
    exp_cnt += 2;
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'hC0C040C0) begin miscompares++; $display("FAIL lwsw_word: got %h want c0c040c0 (seen=%0b)", w, ok); end
`else
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h0044A403) begin miscompares++; $display("FAIL lw_word: got %h want 0044a403 (seen=%0b)", w, ok); end
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h0084A223) begin miscompares++; $display("FAIL sw_word: got %h want 0084a223 (seen=%0b)", w, ok); end
`endif
    vectors++;
    if (oCCOUNT !== cnt_model()) begin miscompares++; $display("FAIL ls_ccount: got %0d want %0d", oCCOUNT, cnt_model()); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    bit ok;
    iREADY = 1'b0;
    send(32'h123452B7);
    iVALID = 1'b1;
    iINSTR = 32'h00100093;
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      vectors++;
      if (oVALID !== 1'b1 || oWORD !== 32'h123452B7 || oREADY !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%0b w=%h r=%0b want v=1 w=123452b7 r=0", i, oVALID, oWORD, oREADY);
      end
    end
    @(posedge iCLK);
    #1;
    iREADY = 1'b1;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    exp_cnt += 1;
    vectors++;
    if (oHALF !== 1'b1) begin miscompares++; $display("FAIL stall_ohalf: got %0b want 1", oHALF); end
    send(32'h123452B7);
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h123452B7) begin miscompares++; $display("FAIL stall_first: got %h want 123452b7 (seen=%0b)", w, ok); end
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h52B74085) begin miscompares++; $display("FAIL stall_second: got %h want 52b74085 (seen=%0b)", w, ok); end
    iFLUSH = 1'b1;
    @(posedge iCLK);
    #1;
    iFLUSH = 1'b0;
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h00011234) begin miscompares++; $display("FAIL stall_flush: got %h want 00011234 (seen=%0b)", w, ok); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    bit ok;
    exp_q.push_back(32'h952E4515);
    exp_q.push_back(32'h123452B7);
    exp_q.push_back(32'h52B74515);
    exp_q.push_back(32'h952E1234);
    send(32'h00500513);
    send(32'h00B50533);
    send(32'h123452B7);
    send(32'h00500513);
    send(32'h123452B7);
    send(32'h00B50533);
    exp_cnt += 4;
    while (exp_q.size() != 0) begin
      get_word(w, ok);
      vectors++;
      if (!ok || w !== exp_q[0]) begin miscompares++; $display("FAIL b2b_word: got %h want %h (seen=%0b)", w, exp_q[0], ok); end
      void'(exp_q.pop_front());
    end
    vectors++;
    if (oCCOUNT !== cnt_model()) begin miscompares++; $display("FAIL b2b_ccount: got %0d want %0d", oCCOUNT, cnt_model()); end
  endtask

  task automatic test_saturate();
    logic [31:0] w;
    bit ok;
    for (int i = 0; i < 16; i++) send(32'h00500513);
    exp_cnt += 16;
    for (int i = 0; i < 8; i++) begin
      get_word(w, ok);
      vectors++;
      if (!ok || w !== 32'h45154515) begin miscompares++; $display("FAIL sat_word[%0d]: got %h want 45154515 (seen=%0b)", i, w, ok); end
    end
    vectors++;
    if (oCCOUNT !== 4'd15) begin miscompares++; $display("FAIL sat_ccount: got %0d want 15", oCCOUNT); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    bit ok;
    send(32'h00500513);
    iREADY = 1'b0;
    send(32'h123452B7);
    iRST = 1'b1;
    exp_cnt = 0;
    #2;
    vectors++;
    if (oVALID !== 1'b0 || oHALF !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_clear: got v=%0b h=%0b want v=0 h=0", oVALID, oHALF);
    end
    vectors++;
    if (oCCOUNT !== 4'd0) begin miscompares++; $display("FAIL midreset_ccount: got %0d want 0", oCCOUNT); end
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    iREADY = 1'b1;
    send(32'h00500513);
    send(32'h00B50533);
    exp_cnt += 2;
    get_word(w, ok);
    vectors++;
    if (!ok || w !== 32'h952E4515) begin miscompares++; $display("FAIL midreset_word: got %h want 952e4515 (seen=%0b)", w, ok); end
    vectors++;
    if (oCCOUNT !== cnt_model() || oHALF !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: got cnt=%0d h=%0b want cnt=%0d h=0", oCCOUNT, oHALF, cnt_model());
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_pack_pair();
    test_uncompressed();
    test_half_flush();
    test_addi_forms();
    test_loadstore();
    test_stall();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    repeat (3) @(posedge iCLK);
    #1;
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL stray_words: got %0d want 0", obs_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
